// File: rtl/c0_uart_yukleyici_if.sv
// Memory write port of the C0 UART program loader: valid/ready handshake,
// byte address and 32-bit data. The loader drives the master side.
interface c0_uart_yukleyici_if;
   logic        gecerli;
   logic [31:0] adres;
   logic [31:0] veri;
   logic        hazir;

   modport master (output gecerli, output adres, output veri, input hazir);
   modport slave  (input gecerli, input adres, input veri, output hazir);
endinterface

// File: rtl/c0_uart_yukleyici.sv
// C0 UART program loader: 8N1 receiver, little-endian word assembly, memory writes, core reset release.
// Optional byte echo on tx_o is enabled by defining C0_YUKLEYICI_YANKI_EN.
//
// Loader FSM states
//   state | meaning
//   SAYI  | collecting the 4 bytes of word count N
//   VERI  | collecting the 4 bytes of word i
//   YAZ   | write request held until the memory accepts it
//   BITTI | load done, core released, further bytes ignored
module c0_uart_yukleyici #(
   parameter int          CLKS_PER_BIT = 87,
   parameter logic [31:0] BASE_ADDR    = 32'h0001_0000
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        rx_i,
   output logic                        tx_o,
   c0_uart_yukleyici_if.master         bellek,
   output logic                        cekirdek_rst_no,
   output logic                        yukleme_bitti_o,
   output logic                        hata_o
);

   localparam int SW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [SW-1:0] YARIM = SW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [SW-1:0] TAM   = SW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {R_BOS, R_BASLA, R_VERI, R_DUR, R_BEKLE} rx_durum_t;
   typedef enum logic [1:0] {SAYI, VERI, YAZ, BITTI} yuk_durum_t;

   logic            rx_s1_q, rx_s2_q;
   rx_durum_t       rx_q;
   logic [SW-1:0]   sayac_q;
   logic [2:0]      bit_q;
   logic [7:0]      kaydirma_q;
   logic [7:0]      tut_q;
   logic            dolu_q;
   logic            hata_q;

   yuk_durum_t      yuk_q;
   logic [1:0]      bayt_q;
   logic [31:0]     n_q;
   logic [31:0]     i_q;
   logic [31:0]     kelime_q;
   logic            gecerli_q;
   logic [31:0]     adres_q;
   logic [31:0]     veri_q;
   logic            bitti_q;
   logic            cekirdek_q;

   logic            tuket;
   logic            yanki_atla;

   // The holding byte is drained in every state except YAZ, where it must wait.
   assign tuket = dolu_q && (yuk_q != YAZ);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_q       <= R_BOS;
         sayac_q    <= '0;
         bit_q      <= '0;
         kaydirma_q <= '0;
         tut_q      <= '0;
         dolu_q     <= 1'b0;
         hata_q     <= 1'b0;
      end else begin
         rx_s1_q <= rx_i;
         rx_s2_q <= rx_s1_q;
         if (tuket)      dolu_q <= 1'b0;
         if (yanki_atla) hata_q <= 1'b1;
         case (rx_q)
            R_BOS: if (!rx_s2_q) begin
               rx_q    <= R_BASLA;
               sayac_q <= YARIM;
            end
            R_BASLA: if (sayac_q == '0) begin
               if (rx_s2_q) rx_q <= R_BOS;
               else begin
                  rx_q    <= R_VERI;
                  sayac_q <= TAM;
                  bit_q   <= 3'd7;
               end
            end else sayac_q <= sayac_q - 1'b1;
            R_VERI: if (sayac_q == '0) begin
               kaydirma_q <= {rx_s2_q, kaydirma_q[7:1]};
               sayac_q    <= TAM;
               if (bit_q == 3'd0) rx_q <= R_DUR;
               else               bit_q <= bit_q - 3'd1;
            end else sayac_q <= sayac_q - 1'b1;
            R_DUR: if (sayac_q == '0) begin
               if (rx_s2_q) begin
                  // A byte drained this very cycle frees the slot, so it is not an overrun.
                  if (dolu_q && !tuket) hata_q <= 1'b1;
                  else begin
                     tut_q  <= kaydirma_q;
                     dolu_q <= 1'b1;
                  end
                  rx_q <= R_BOS;
               end else begin
                  hata_q <= 1'b1;
                  rx_q   <= R_BEKLE;
               end
            end else sayac_q <= sayac_q - 1'b1;
            R_BEKLE: if (rx_s2_q) rx_q <= R_BOS;
            default: rx_q <= R_BOS;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         yuk_q      <= SAYI;
         bayt_q     <= '0;
         n_q        <= '0;
         i_q        <= '0;
         kelime_q   <= '0;
         gecerli_q  <= 1'b0;
         adres_q    <= '0;
         veri_q     <= '0;
         bitti_q    <= 1'b0;
         cekirdek_q <= 1'b0;
      end else begin
         case (yuk_q)
            SAYI: if (tuket) begin
               n_q    <= {tut_q, n_q[31:8]};
               bayt_q <= bayt_q + 2'd1;
               if (bayt_q == 2'd3) begin
                  if ({tut_q, n_q[31:8]} == 32'd0) begin
                     yuk_q      <= BITTI;
                     bitti_q    <= 1'b1;
                     cekirdek_q <= 1'b1;
                  end else yuk_q <= VERI;
               end
            end
            VERI: if (tuket) begin
               kelime_q <= {tut_q, kelime_q[31:8]};
               bayt_q   <= bayt_q + 2'd1;
               if (bayt_q == 2'd3) begin
                  yuk_q     <= YAZ;
                  gecerli_q <= 1'b1;
                  adres_q   <= BASE_ADDR + (i_q << 2);
                  veri_q    <= {tut_q, kelime_q[31:8]};
               end
            end
            YAZ: if (bellek.hazir) begin
               gecerli_q <= 1'b0;
               i_q       <= i_q + 32'd1;
               if (i_q + 32'd1 == n_q) begin
                  yuk_q      <= BITTI;
                  bitti_q    <= 1'b1;
                  cekirdek_q <= 1'b1;
               end else yuk_q <= VERI;
            end
            BITTI: ;
            default: yuk_q <= SAYI;
         endcase
      end
   end

`ifdef C0_YUKLEYICI_YANKI_EN
   logic [7:0]    tx_tampon_q;
   logic          tx_dolu_q;
   logic [8:0]    tx_kaydir_q;
   logic [3:0]    tx_bit_q;
   logic [SW-1:0] tx_sayac_q;
   logic          tx_mesgul_q;
   logic          tx_q;

   assign yanki_atla = tuket && tx_dolu_q;
   assign tx_o       = tx_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_tampon_q <= '0;
         tx_dolu_q   <= 1'b0;
         tx_kaydir_q <= '1;
         tx_bit_q    <= '0;
         tx_sayac_q  <= '0;
         tx_mesgul_q <= 1'b0;
         tx_q        <= 1'b1;
      end else begin
         if (tuket && !tx_dolu_q) begin
            tx_tampon_q <= tut_q;
            tx_dolu_q   <= 1'b1;
         end
         if (!tx_mesgul_q) begin
            if (tx_dolu_q) begin
               tx_dolu_q   <= 1'b0;
               tx_mesgul_q <= 1'b1;
               tx_q        <= 1'b0;
               tx_kaydir_q <= {1'b1, tx_tampon_q};
               tx_bit_q    <= 4'd9;
               tx_sayac_q  <= TAM;
            end
         end else if (tx_sayac_q == '0) begin
            tx_sayac_q <= TAM;
            if (tx_bit_q == 4'd0) tx_mesgul_q <= 1'b0;
            else begin
               tx_q        <= tx_kaydir_q[0];
               tx_kaydir_q <= {1'b1, tx_kaydir_q[8:1]};
               tx_bit_q    <= tx_bit_q - 4'd1;
            end
         end else tx_sayac_q <= tx_sayac_q - 1'b1;
      end
   end
`else
   assign yanki_atla = 1'b0;
   assign tx_o       = 1'b1;
`endif

   assign bellek.gecerli  = gecerli_q;
   assign bellek.adres    = adres_q;
   assign bellek.veri     = veri_q;
   assign cekirdek_rst_no = cekirdek_q;
   assign yukleme_bitti_o = bitti_q;
   assign hata_o          = hata_q;

endmodule
